// File: rtl/bias_pkg.sv
// rtl/bias_pkg.sv - shared width, saturation constants and lane helpers for the bias bank
package bias_pkg;

    localparam int W_DEF = 18;

    localparam logic [W_DEF-1:0] MAX_POS = {1'b0, {(W_DEF-1){1'b1}}};
    localparam logic [W_DEF-1:0] MAX_NEG = {1'b1, {(W_DEF-1){1'b0}}};

    // Returns {sat, sum}; the extra sum bit disagreeing with the sign bit means overflow.
    function automatic logic [W_DEF:0] sat_add(input logic [W_DEF-1:0] a,
                                               input logic [W_DEF-1:0] b);
        logic [W_DEF:0] s;
        s = {a[W_DEF-1], a} + {b[W_DEF-1], b};
        if (s[W_DEF] != s[W_DEF-1])
            return {1'b1, (s[W_DEF] ? MAX_NEG : MAX_POS)};
        return {1'b0, s[W_DEF-1:0]};
    endfunction

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/bias_sat_add.sv
// rtl/bias_sat_add.sv - one-lane two's-complement adder with saturation
module bias_sat_add
    import bias_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);

    generate
        if (W == W_DEF) begin : g_pkg
            assign {sat, sum} = sat_add(a, b);
        end else begin : g_generic
            logic [W:0] s;
            assign s   = {a[W-1], a} + {b[W-1], b};
            assign sat = (s[W] != s[W-1]);
            assign sum = !sat ? s[W-1:0] :
                         s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    endgenerate

endmodule

// File: rtl/bias_bank_adder.sv
// rtl/bias_bank_adder.sv - runtime-loadable bias store with saturating bias-add output stage
module bias_bank_adder
    import bias_pkg::*;
#(
    parameter int N_adder_tree = 16,
    parameter int W            = W_DEF,
    parameter int N_GROUPS     = 8,
    parameter int GW           = $clog2(N_GROUPS),
    parameter int LW           = $clog2(N_adder_tree)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [GW-1:0]             cfg_group,
    input  logic [LW-1:0]             cfg_lane,
    input  logic [W-1:0]              cfg_data,
    input  logic [GW:0]               n_groups_active,
    input  logic                      group_restart,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_adder_tree*W-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_adder_tree*W-1:0] out_data,
    output logic [GW-1:0]             out_group,
    output logic [N_adder_tree-1:0]   out_sat
);

    localparam logic [GW:0] NG = (GW+1)'(N_GROUPS);

    logic [W-1:0]              bias_mem [N_GROUPS][N_adder_tree];
    logic [GW-1:0]             ptr;
    logic [GW:0]               n_eff;
    logic [GW:0]               ptr_inc;
    logic [GW-1:0]             ptr_nxt;
    logic                      acc;
    logic                      cfg_ok;
    logic [N_adder_tree*W-1:0] sum_data;
    logic [N_adder_tree-1:0]   sum_sat;

    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;

    // Writes that address past the populated bank (non power-of-two sizes) are dropped.
    assign cfg_ok = ({{(32-GW){1'b0}}, cfg_group} < N_GROUPS) &&
                    ({{(32-LW){1'b0}}, cfg_lane}  < N_adder_tree);

    always_comb begin
        n_eff   = NG;
        ptr_nxt = '0;
        if (n_groups_active != '0 && n_groups_active <= NG)
            n_eff = n_groups_active;
        ptr_inc = {1'b0, ptr} + (GW+1)'(1);
        // ">=" also catches a pointer stranded above a freshly reduced count.
        if (ptr_inc < n_eff)
            ptr_nxt = ptr_inc[GW-1:0];
    end

    generate
        for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
            bias_sat_add #(.W(W)) u_add (
                .a   (in_data[lane_lo(i, W) +: W]),
                .b   (bias_mem[ptr][i]),
                .sum (sum_data[lane_lo(i, W) +: W]),
                .sat (sum_sat[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < N_GROUPS; g++)
                for (int l = 0; l < N_adder_tree; l++)
                    bias_mem[g][l] <= '0;
        end else if (cfg_we && cfg_ok) begin
            bias_mem[cfg_group][cfg_lane] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (group_restart) begin
            ptr <= '0;
        end else if (acc) begin
            ptr <= ptr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_group <= '0;
            out_sat   <= '0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_data  <= sum_data;
            out_group <= ptr;
            out_sat   <= sum_sat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bias_bank_adder.sv
// tb/tb_bias_bank_adder.sv - scoreboard bench for bias_bank_adder
module tb_bias_bank_adder;

    localparam int NL = 16;
    localparam int W  = 18;
    localparam int NG = 8;
    localparam int DW = NL * W;

    typedef struct {
        logic [DW-1:0] data;
        logic [2:0]    group;
        logic [NL-1:0] sat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [2:0]    cfg_group;
    logic [3:0]    cfg_lane;
    logic [W-1:0]  cfg_data;
    logic [3:0]    n_groups_active;
    logic          group_restart;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    out_group;
    logic [NL-1:0] out_sat;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [W-1:0] bm [NG][NL];
    int   mptr;

    bias_bank_adder dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_group(cfg_group),
        .cfg_lane(cfg_lane), .cfg_data(cfg_data), .n_groups_active(n_groups_active),
        .group_restart(group_restart), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_group(out_group), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    function automatic int sx(input logic [W-1:0] v);
        return v[W-1] ? int'(v) - (1 << W) : int'(v);
    endfunction

    function automatic int model_neff();
        int n;
        n = int'(n_groups_active);
        return (n == 0 || n > NG) ? NG : n;
    endfunction

    function automatic exp_t model_beat(input logic [DW-1:0] d);
        exp_t e;
        int   s;
        e.group = mptr[2:0];
        for (int i = 0; i < NL; i++) begin
            s = sx(d[i*W +: W]) + sx(bm[mptr][i]);
            if (s > 131071) begin
                e.data[i*W +: W] = 18'h1FFFF; e.sat[i] = 1'b1;
            end else if (s < -131072) begin
                e.data[i*W +: W] = 18'h20000; e.sat[i] = 1'b1;
            end else begin
                e.data[i*W +: W] = s[W-1:0];  e.sat[i] = 1'b0;
            end
        end
        return e;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < NL; i++) d[i*W +: W] = W'($urandom);
        return d;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL extra_beat got group %0d data %h, required no beat", out_group, out_data);
            end else begin
                e = sb.pop_front();
                checks++;
                if (out_data !== e.data) begin
                    errors++;
                    $display("FAIL out_data got %h required %h", out_data, e.data);
                end
                checks++;
                if (out_group !== e.group) begin
                    errors++;
                    $display("FAIL out_group got %0d required %0d", out_group, e.group);
                end
                checks++;
                if (out_sat !== e.sat) begin
                    errors++;
                    $display("FAIL out_sat got %h required %h", out_sat, e.sat);
                end
            end
        end
    end

    task automatic cfg_write(input int g, input int l, input logic [W-1:0] v);
        cfg_we = 1'b1; cfg_group = g[2:0]; cfg_lane = l[3:0]; cfg_data = v;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        bm[g][l] = v;
    endtask

    task automatic restart();
        in_valid = 1'b0; group_restart = 1'b1;
        @(posedge clk); #1;
        group_restart = 1'b0;
        mptr = 0;
    endtask

    // Leaves in_valid high so consecutive calls stream back-to-back.
    task automatic send_beat(input logic [DW-1:0] d, input logic rs, input logic we,
                             input int g, input int l, input logic [W-1:0] v);
        logic acc_now;
        int   n;
        in_data = d; in_valid = 1'b1; group_restart = rs;
        cfg_we = we; cfg_group = g[2:0]; cfg_lane = l[3:0]; cfg_data = v;
        acc_now = 1'b0;
        n = 0;
        while (!acc_now && n < 50) begin
            @(negedge clk);
            acc_now = in_ready;
            if (acc_now) begin
                sb.push_back(model_beat(d));
                mptr = (mptr + 1 >= model_neff()) ? 0 : mptr + 1;
                if (rs) mptr = 0;
                if (we) bm[g][l] = v;
            end
            @(posedge clk); #1;
            n++;
        end
        group_restart = 1'b0; cfg_we = 1'b0;
        if (!acc_now) begin
            checks++; errors++;
            $display("FAIL accept_timeout got no accept in %0d cycles required accept", n);
        end
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending beats required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs got valid %b ready %b required 0 1", out_valid, in_ready);
        end
        checks++;
        if (out_data !== '0 || out_group !== 3'd0 || out_sat !== '0) begin
            errors++;
            $display("FAIL reset_out got %h %0d %h required zeros", out_data, out_group, out_sat);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [DW-1:0] d;
        cfg_write(0, 0, 18'h00868);
        d = '0;
        d[0 +: W] = 18'd100;
        send_beat(d, 1'b0, 1'b0, 0, 0, '0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency got out_valid %b required 1", out_valid);
        end
        checks++;
        if (out_data[0 +: W] !== 18'd2252) begin
            errors++;
            $display("FAIL basic_lane0 got %0d required 2252", out_data[0 +: W]);
        end
        send_beat(rand_data(), 1'b0, 1'b0, 0, 0, '0);
        drain();
    endtask

    task automatic test_saturation();
        logic [DW-1:0] d;
        restart();
        cfg_write(0, 0, 18'h1F000);
        cfg_write(0, 1, 18'h3DB60);
        d = '0;
        d[0 +: W] = 18'h01000;
        d[W +: W] = 18'h20000;
        send_beat(d, 1'b0, 1'b0, 0, 0, '0);
        #1;
        checks++;
        if (out_data[0 +: W] !== 18'h1FFFF || out_sat[0] !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos got %h sat %b required 1ffff 1", out_data[0 +: W], out_sat[0]);
        end
        checks++;
        if (out_data[W +: W] !== 18'h20000 || out_sat[1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg got %h sat %b required 20000 1", out_data[W +: W], out_sat[1]);
        end
        drain();
    endtask

    task automatic test_wrap();
        for (int g = 0; g < NG; g++)
            for (int l = 0; l < 3; l++)
                cfg_write(g, l, W'($urandom_range(0, 4095)));
        n_groups_active = 4'd3;
        restart();
        for (int k = 0; k < 7; k++) send_beat(rand_data(), 1'b0, 1'b0, 0, 0, '0);
        drain();
        n_groups_active = 4'd0;
        restart();
        for (int k = 0; k < 9; k++) send_beat(rand_data(), 1'b0, 1'b0, 0, 0, '0);
        drain();
        n_groups_active = 4'd12;
        restart();
        for (int k = 0; k < 9; k++) send_beat(rand_data(), 1'b0, 1'b0, 0, 0, '0);
        drain();
    endtask

    task automatic test_back_to_back_shrink();
        n_groups_active = 4'd0;
        restart();
        for (int k = 0; k < 6; k++) send_beat(rand_data(), 1'b0, 1'b0, 0, 0, '0);
        n_groups_active = 4'd2;
        for (int k = 0; k < 4; k++) send_beat(rand_data(), 1'b0, 1'b0, 0, 0, '0);
        drain();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] b;
        n_groups_active = 4'd0;
        restart();
        out_ready = 1'b0;
        send_beat(rand_data(), 1'b0, 1'b0, 0, 0, '0);
        b = rand_data();
        in_data = b;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hs got ready %b valid %b required 0 1", in_ready, out_valid);
            end
            checks++;
            if (out_data !== sb[0].data || out_group !== sb[0].group) begin
                errors++;
                $display("FAIL bp_hold got %h grp %0d required %h grp %0d", out_data, out_group, sb[0].data, sb[0].group);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_beat(b, 1'b0, 1'b0, 0, 0, '0);
        send_beat(rand_data(), 1'b0, 1'b0, 0, 0, '0);
        drain();
    endtask

    task automatic test_simultaneous();
        n_groups_active = 4'd0;
        restart();
        send_beat(rand_data(), 1'b0, 1'b0, 0, 0, '0);
        send_beat(rand_data(), 1'b0, 1'b0, 0, 0, '0);
        send_beat(rand_data(), 1'b1, 1'b0, 0, 0, '0);
        send_beat(rand_data(), 1'b0, 1'b0, 0, 0, '0);
        drain();
        n_groups_active = 4'd1;
        restart();
        cfg_write(0, 3, 18'd500);
        send_beat(rand_data(), 1'b0, 1'b1, 0, 3, 18'h3FC18);
        send_beat(rand_data(), 1'b0, 1'b0, 0, 0, '0);
        drain();
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        n_groups_active = 4'd0;
        restart();
        out_ready = 1'b0;
        send_beat(rand_data(), 1'b0, 1'b0, 0, 0, '0);
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid got valid %b ready %b required 0 1", out_valid, in_ready);
        end
        sb.delete();
        for (int g = 0; g < NG; g++)
            for (int l = 0; l < NL; l++) bm[g][l] = '0;
        mptr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        d = rand_data();
        send_beat(d, 1'b0, 1'b0, 0, 0, '0);
        #1;
        checks++;
        if (out_data !== d || out_group !== 3'd0) begin
            errors++;
            $display("FAIL rst_raw got %h grp %0d required %h grp 0", out_data, out_group, d);
        end
        drain();
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_group = '0; cfg_lane = '0; cfg_data = '0;
        n_groups_active = 4'd0; group_restart = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b1; mptr = 0;
        for (int g = 0; g < NG; g++)
            for (int l = 0; l < NL; l++) bm[g][l] = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_wrap();
        test_back_to_back_shrink();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bias_bank_adder.md
# bias_bank_adder

Runtime-loadable bias store and bias-add pipeline stage for the adder-tree datapath. It holds 18-bit two's-complement biases for `N_GROUPS` output-channel groups × `N_adder_tree` lanes, replacing per-layer constant bias modules. Accumulated lane sums stream in over a valid/ready handshake. The block adds the current group's biases with saturation and advances the group pointer per beat, wrapping at a programmable group count.

## Interface
- `N_adder_tree`, 16, lanes per beat
- `W`, 18, lane data and bias width (two's complement)
- `N_GROUPS`, 8, bias groups stored; `GW = $clog2(N_GROUPS)`, `LW = $clog2(N_adder_tree)`

- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `cfg_we` in 1: bias write strobe
- `cfg_group` in GW: group written
- `cfg_lane` in LW: lane written
- `cfg_data` in W: bias value
- `n_groups_active` in GW+1: wrap count; 0 or >N_GROUPS means N_GROUPS
- `group_restart` in 1: pulse, pointer to 0
- `in_valid` in 1, `in_ready` out 1, `in_data` in N_adder_tree*W: lane i at `[W*(i+1)-1:W*i]`
- `out_valid` out 1, `out_ready` in 1, `out_data` out N_adder_tree*W: same packing
- `out_group` out GW: group index used for the current output
- `out_sat` out N_adder_tree: per-lane saturation flag for the current output

## Operation
- Storage: a register array `bias[g][l]`. The read is combinational from the pointer `ptr`.
- Config write: on a `cfg_we` edge, `bias[cfg_group][cfg_lane] <= cfg_data`. The write is independent of the handshake.
  - A same-cycle write to the group being consumed is not seen by that beat; the old value is used.
  - Out-of-range `cfg_lane` or `cfg_group` (non-power-of-2 params) are ignored.
- Accept: `acc = in_valid && in_ready`. On `acc`, for each lane:
  - `s = sext(in_i) + sext(bias[ptr][i])`, W+1 bits.
  - If `s > 2^(W-1)-1`, output `0x1FFFF` with `out_sat[i]=1`.
  - If `s < -2^(W-1)`, output `0x20000` with `out_sat[i]=1`.
  - Otherwise output `s[W-1:0]` with `out_sat[i]=0`.
  - `out_group <= ptr`.
- Pointer update on `acc`: `ptr <= (ptr+1 >= n_eff) ? 0 : ptr+1`, where `n_eff` is the effective `n_groups_active`. If `ptr` is already ≥ `n_eff` after a count shrink, the next accept wraps it to 0.
- `group_restart`: `ptr <= 0`. It takes priority over the `acc` increment. A beat accepted in the same cycle uses the old `ptr`.

## Timing
- Single output register stage; latency is 1 cycle from accept to `out_valid`.
- `in_ready = !out_valid || out_ready`. This gives full throughput of 1 beat/cycle under continuous `out_ready`.
- `out_valid` rises the cycle after `acc`. It falls after `out_valid && out_ready` with no new `acc`.
- While `out_valid && !out_ready`, `out_data`, `out_group` and `out_sat` hold stable and `in_ready=0`.
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_group=0`, `out_sat=0`, `ptr=0`
  - all `bias` entries 0
  - `in_ready=1` (combinational from `out_valid=0`)
- Reset mid-stream: the in-flight output is discarded and `out_valid` drops asynchronously. Biases are cleared, so software must reload them.
- No combinational path from `in_valid` to `in_ready`. `out_ready` reaches `in_ready` combinationally only.

## Structure
- Package `bias_pkg`:
  - `W` default
  - `sat_add(a, b)` function returning `{sat, sum[W-1:0]}`
  - lane-slice helper macro/function
  - `MAX_POS`/`MAX_NEG` constants
- Sub-module `bias_sat_add` (one lane, combinational adder plus saturate) is instantiated `N_adder_tree` times in a generate loop. The top module owns storage, pointer, handshake and output register.

## Test plan
- Load the group-0 lane-0 bias `0x00868` (2152). Send in lane 0 = 100 → `out_data` lane 0 = 2252, `out_sat[0]=0`, `out_group=0`, one cycle after accept.
- Saturation:
  - bias `0x1F000` + input `0x01000` → `0x1FFFF`, `out_sat=1`.
  - bias `0x3DB60` (negative) + input `0x20000` → `0x20000`, `out_sat=1`.
- Wrap: `n_groups_active=3`, 7 back-to-back beats → `out_group` sequence 0,1,2,0,1,2,0. Repeat with `n_groups_active=0` → sequence 0..7,0.
- Backpressure: hold `out_ready=0` for 4 cycles with `in_valid=1` → output is stable, `in_ready=0`, `ptr` is frozen, and no beat is lost or duplicated after release.
- Simultaneous events:
  - `group_restart` with accept at `ptr=2` → the beat uses group 2 and the next beat uses group 0.
  - `cfg_we` to the active group in the accept cycle → the old bias is used and the next beat to that group uses the new bias.
- Assert `rst` while `out_valid=1` → `out_valid=0` immediately, and every lane outputs the raw input (bias 0) after reset.
